// File: rtl/apb4_master_pkg.sv
// -----------------------------------------------------------------------------
// apb4_master_pkg
//   Shared definitions for the APB4 initiator.
//   - apb_state_t : FSM encoding, 2 bits, IDLE = 0
//   - APB4_TIMEOUT_CYCLES_DEFAULT : default ACCESS wait limit for the timeout build
//   - tmo_cnt_width() : width of the ACCESS wait counter for a given limit
// Optional feature macro used by the files importing this package:
//   APB4_MASTER_TIMEOUT_EN
// -----------------------------------------------------------------------------
package apb4_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_t;

    localparam int APB4_TIMEOUT_CYCLES_DEFAULT = 256;

    // The counter only has to reach cycles-1, so clog2(cycles) bits suffice.
    function automatic int tmo_cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/apb4_if.sv
// -----------------------------------------------------------------------------
// apb4_if
//   APB4 bus bundle between one initiator and its register slaves.
//   Inputs : pclk, presetn (asynchronous, active-low)
//   master modport: drives paddr pprot psel penable pwrite pwdata pstrb,
//                   receives pready prdata pslverr
//   slave modport : the mirror image
// -----------------------------------------------------------------------------
interface apb4_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input logic pclk,
    input logic presetn
);
    logic [ADDR_WIDTH-1:0]   paddr;
    logic [2:0]              pprot;
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic [DATA_WIDTH/8-1:0] pstrb;
    logic                    pready;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pslverr;

    modport master (
        input  pclk, presetn, pready, prdata, pslverr,
        output paddr, pprot, psel, penable, pwrite, pwdata, pstrb
    );

    modport slave (
        input  pclk, presetn, paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb4_master_wdt.sv
// -----------------------------------------------------------------------------
// apb4_master_wdt
//   ACCESS-phase wait counter. Used only when APB4_MASTER_TIMEOUT_EN is defined.
//   Ports:
//     clk     in  clock
//     rst_n   in  asynchronous active-low reset
//     clr     in  restart the count (asserted on the cycle before ACCESS)
//     en      in  count this cycle (ACCESS with pready low)
//     expired out count sits at TIMEOUT_CYCLES-1 and another wait cycle is seen
// -----------------------------------------------------------------------------
module apb4_master_wdt
    import apb4_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = APB4_TIMEOUT_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int             CW   = tmo_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]  TERM = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en && (r_cnt != TERM)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // The counter value equals the number of wait cycles already seen, so the
    // TIMEOUT_CYCLES-th consecutive wait cycle finds it at TERM.
    assign expired = en && (r_cnt == TERM);

endmodule

// File: rtl/apb4_master.sv
// -----------------------------------------------------------------------------
// apb4_master
//   Single-outstanding APB4 initiator. A valid/ready command is turned into an
//   APB4 SETUP -> ACCESS transfer (PREADY wait states honoured) and the result
//   is returned on a valid/ready response channel.
//   Ports:
//     apb4         master modport (pclk, presetn, APB4 bus)
//     req_valid_i  command valid          req_ready_o command accepted
//     req_addr_i   byte address           req_write_i 1=write, 0=read
//     req_wdata_i  write data             req_strb_i  write byte strobes
//     req_prot_i   PPROT value
//     rsp_valid_o  response valid (held)  rsp_ready_i response consumed
//     rsp_rdata_o  read data, 0 for writes
//     rsp_err_o    PSLVERR or timeout     rsp_tmo_o   response was a timeout
//   Build option: APB4_MASTER_TIMEOUT_EN adds the ACCESS timeout; without it
//   ACCESS waits indefinitely and rsp_tmo_o is 0.
//   DATA_WIDTH must be 8, 16 or 32.
// -----------------------------------------------------------------------------
module apb4_master
    import apb4_master_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = APB4_TIMEOUT_CYCLES_DEFAULT
) (
    apb4_if.master                  apb4,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic                    req_write_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] req_strb_i,
    input  logic [2:0]              req_prot_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic                    rsp_tmo_o
);
    logic w_clk;
    logic w_rst_n;
    assign w_clk   = apb4.pclk;
    assign w_rst_n = apb4.presetn;

    apb_state_t              r_state;
    apb_state_t              w_state_next;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_write;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH/8-1:0] r_strb;
    logic [2:0]              r_prot;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    r_err;

    logic w_accept;
    logic w_capture;
    logic w_abort;
    logic w_tmo_expired;

    // Gated by presetn so the command channel reads not-ready while in reset.
    assign req_ready_o = w_rst_n &&
                         ((r_state == ST_IDLE) || ((r_state == ST_RESP) && rsp_ready_i));
    assign w_accept    = req_valid_i && req_ready_o;

    // ------------------------------------------------------------------ FSM
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid_i) begin
                    w_state_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                // A completing PREADY takes priority over the timeout.
                if (apb4.pready) begin
                    w_state_next = ST_RESP;
                    w_capture    = 1'b1;
                end else if (w_tmo_expired) begin
                    w_state_next = ST_RESP;
                    w_abort      = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    w_state_next = req_valid_i ? ST_SETUP : ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_strb  <= '0;
            r_prot  <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            // Reads store zero data/strobes so PWDATA/PSTRB are 0 on the bus.
            if (w_accept) begin
                r_addr  <= req_addr_i;
                r_write <= req_write_i;
                r_wdata <= req_write_i ? req_wdata_i : '0;
                r_strb  <= req_write_i ? req_strb_i : '0;
                r_prot  <= req_prot_i;
            end
            if (w_capture) begin
                r_rdata <= r_write ? '0 : apb4.prdata;
                r_err   <= apb4.pslverr;
            end else if (w_abort) begin
                r_rdata <= '0;
                r_err   <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------- timeout option
`ifdef APB4_MASTER_TIMEOUT_EN
    logic r_tmo;

    apb4_master_wdt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdt (
        .clk     (w_clk),
        .rst_n   (w_rst_n),
        .clr     (r_state == ST_SETUP),
        .en      ((r_state == ST_ACCESS) && !apb4.pready),
        .expired (w_tmo_expired)
    );

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_tmo <= 1'b0;
        end else if (w_capture) begin
            r_tmo <= 1'b0;
        end else if (w_abort) begin
            r_tmo <= 1'b1;
        end
    end

    assign rsp_tmo_o = r_tmo;
`else
    logic w_unused_cfg;
    assign w_unused_cfg  = (TIMEOUT_CYCLES == 0);
    assign w_tmo_expired = 1'b0;
    assign rsp_tmo_o     = 1'b0;
`endif

    // -------------------------------------------------------------- outputs
    // Strobes derive from the state register, so an asynchronous reset drops
    // them immediately.
    assign apb4.psel    = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
    assign apb4.penable = (r_state == ST_ACCESS);
    assign apb4.paddr   = r_addr;
    assign apb4.pwrite  = r_write;
    assign apb4.pwdata  = r_wdata;
    assign apb4.pstrb   = r_strb;
    assign apb4.pprot   = r_prot;

    assign rsp_valid_o  = (r_state == ST_RESP);
    assign rsp_rdata_o  = r_rdata;
    assign rsp_err_o    = r_err;

endmodule

// File: tb/tb_apb4_master.sv
// -----------------------------------------------------------------------------
// tb_apb4_master
//   The bench plays both the command/response user and the APB4 slave. Each
//   transfer is described by its command and slave behaviour (wait states,
//   error, read data); the expected bus activity and response are derived from
//   that description. Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_apb4_master;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 8;
`ifdef APB4_MASTER_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          req_write;
    logic [DW-1:0] req_wdata;
    logic [SW-1:0] req_strb;
    logic [2:0]    req_prot;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_tmo;

    int checks  = 0;
    int errors  = 0;
    bit pending = 1'b0;

    always #5 clk = ~clk;

    apb4_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_apb (.pclk(clk), .presetn(rst_n));

    apb4_master #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .apb4        (u_apb),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_addr_i  (req_addr),
        .req_write_i (req_write),
        .req_wdata_i (req_wdata),
        .req_strb_i  (req_strb),
        .req_prot_i  (req_prot),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .rsp_tmo_o   (rsp_tmo)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One complete transfer. Entered on a falling edge; if a response is still
    // pending it is consumed in the same cycle the new command is offered.
    // Leaves the new response pending. rst_at >= 0 asserts reset on that
    // ACCESS cycle (0-based) and abandons the transfer.
    task automatic run_txn(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input logic [SW-1:0] strb, input logic [2:0] prot, input int waits,
                           input bit slverr, input logic [DW-1:0] rd, input int rsp_delay,
                           input int rst_at);
        logic [DW-1:0] exp_wdata;
        logic [SW-1:0] exp_strb;
        logic [DW-1:0] exp_rdata;
        bit            tmo;
        int            n_acc;
        exp_wdata = wr ? wdata : '0;
        exp_strb  = wr ? strb : '0;
        tmo       = TMO_EN && (waits >= TMO);
        n_acc     = tmo ? TMO : waits + 1;
        exp_rdata = (tmo || wr) ? '0 : rd;

        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_strb  = strb;
        req_prot  = prot;
        req_valid = 1'b1;
        rsp_ready = pending;
        #1;
        chk("req_ready_on_offer", req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        pending   = 1'b0;
        rsp_ready = 1'b0;
        // Keep offering garbage: the busy master must ignore it.
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_write = ~wr;
        req_strb  = ~strb;
        req_prot  = ~prot;
        $display("txn wr=%0d addr=0x%08h wdata=0x%08h waits=%0d err=%0d delay=%0d",
                 wr, addr, wdata, waits, slverr, rsp_delay);
        chk("setup_psel", u_apb.psel, 1);
        chk("setup_penable", u_apb.penable, 0);
        chk("setup_paddr", u_apb.paddr, addr);
        chk("setup_pwrite", u_apb.pwrite, wr);
        chk("setup_pwdata", u_apb.pwdata, exp_wdata);
        chk("setup_pstrb", u_apb.pstrb, exp_strb);
        chk("setup_pprot", u_apb.pprot, prot);
        chk("setup_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        for (int i = 0; i < n_acc; i++) begin
            if (i == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_psel", u_apb.psel, 0);
                chk("rst_penable", u_apb.penable, 0);
                u_apb.pready = 1'b0;
                req_valid    = 1'b0;
                return;
            end
            chk("access_psel", u_apb.psel, 1);
            chk("access_penable", u_apb.penable, 1);
            chk("access_paddr", u_apb.paddr, addr);
            chk("access_pwdata", u_apb.pwdata, exp_wdata);
            u_apb.pready  = (i == waits);
            u_apb.prdata  = (i == waits) ? rd : DW'($urandom);
            u_apb.pslverr = (i == waits) ? slverr : 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        u_apb.pready  = 1'b0;
        u_apb.pslverr = 1'b0;
        u_apb.prdata  = DW'($urandom);
        chk("resp_psel", u_apb.psel, 0);
        chk("resp_penable", u_apb.penable, 0);
        chk("resp_valid", rsp_valid, 1);
        chk("resp_rdata", rsp_rdata, exp_rdata);
        chk("resp_err", rsp_err, slverr || tmo);
        chk("resp_tmo", rsp_tmo, tmo);
        for (int d = 0; d < rsp_delay; d++) begin
            @(negedge clk);
            chk("hold_valid", rsp_valid, 1);
            chk("hold_rdata", rsp_rdata, exp_rdata);
            chk("hold_req_ready", req_ready, 0);
        end
        pending = 1'b1;
    endtask

    // Consume the pending response without a new command.
    task automatic drain();
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        #1;
        chk("drain_req_ready", req_ready, 1);
        @(negedge clk);
        rsp_ready = 1'b0;
        pending   = 1'b0;
        chk("idle_rsp_valid", rsp_valid, 0);
        chk("idle_req_ready", req_ready, 1);
        chk("idle_psel", u_apb.psel, 0);
    endtask

    initial begin
        req_valid     = 1'b0;
        req_addr      = '0;
        req_write     = 1'b0;
        req_wdata     = '0;
        req_strb      = '0;
        req_prot      = '0;
        rsp_ready     = 1'b0;
        u_apb.pready  = 1'b0;
        u_apb.prdata  = '0;
        u_apb.pslverr = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_psel0", u_apb.psel, 0);
        chk("rst_penable0", u_apb.penable, 0);
        chk("rst_pwrite0", u_apb.pwrite, 0);
        chk("rst_paddr0", u_apb.paddr, 0);
        chk("rst_pwdata0", u_apb.pwdata, 0);
        chk("rst_pstrb0", u_apb.pstrb, 0);
        chk("rst_pprot0", u_apb.pprot, 0);
        chk("rst_rsp_valid0", rsp_valid, 0);
        chk("rst_rsp_rdata0", rsp_rdata, 0);
        chk("rst_rsp_err0", rsp_err, 0);
        chk("rst_rsp_tmo0", rsp_tmo, 0);
        chk("rst_req_ready0", req_ready, 0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_req_ready", req_ready, 1);
        @(negedge clk);

        // Plain write, no wait states.
        run_txn(1'b1, 32'h04, 32'hA5A5_0001, 4'hF, 3'd0, 0, 1'b0, 32'h0, 0, -1);
        drain();
        // Read with three wait states.
        run_txn(1'b0, 32'h08, 32'hDEAD_BEEF, 4'hF, 3'd2, 3, 1'b0, 32'h1234_5678, 0, -1);
        drain();
        // Slave error, then back-to-back traffic with a stalled response.
        run_txn(1'b1, 32'h10, 32'h0000_00FF, 4'h3, 3'd1, 1, 1'b1, 32'h0, 0, -1);
        run_txn(1'b0, 32'h14, 32'h0, 4'h0, 3'd5, 0, 1'b0, 32'hCAFE_F00D, 5, -1);
        run_txn(1'b1, 32'h18, 32'h1111_2222, 4'hC, 3'd7, 2, 1'b0, 32'h0, 1, -1);
        drain();
        // Long stall (aborts in the timeout build), and PREADY on the last allowed cycle.
        run_txn(1'b0, 32'h20, 32'h0, 4'h0, 3'd0, 20, 1'b0, 32'h5555_AAAA, 0, -1);
        drain();
        run_txn(1'b0, 32'h24, 32'h0, 4'h0, 3'd0, TMO - 1, 1'b0, 32'h7777_8888, 0, -1);
        drain();

        for (int n = 0; n < 40; n++) begin
            run_txn(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), SW'($urandom),
                    3'($urandom), $urandom_range(0, 4), ($urandom_range(0, 3) == 0),
                    DW'($urandom), $urandom_range(0, 3), -1);
            if ($urandom_range(0, 1) == 1) begin
                drain();
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    chk("gap_req_ready", req_ready, 1);
                    chk("gap_rsp_valid", rsp_valid, 0);
                end
            end
        end
        if (pending) drain();

        // Reset on the second ACCESS cycle of a read.
        run_txn(1'b0, 32'h30, 32'h0, 4'h0, 3'd3, 5, 1'b0, 32'h9999_0000, 0, 1);
        pending = 1'b0;
        repeat (2) @(negedge clk);
        chk("in_rst_rsp_valid", rsp_valid, 0);
        chk("in_rst_req_ready", req_ready, 0);
        rst_n = 1'b1;
        #1;
        chk("rel_req_ready", req_ready, 1);
        chk("rel_rsp_valid", rsp_valid, 0);
        chk("rel_psel", u_apb.psel, 0);
        chk("rel_paddr", u_apb.paddr, 0);
        @(negedge clk);
        run_txn(1'b1, 32'h34, 32'h0BAD_F00D, 4'h5, 3'd4, 1, 1'b0, 32'h0, 0, -1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
